dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder at the far end of the execute/memory-stage load/store path. It accepts one load or store request at a time over a valid/ready handshake and performs the access against an internal 64-bit-wide word array. It handles byte/half/word/double sizing from `funct3`, little-endian lane steering, sign/zero extension and alignment checking. It returns a response after a fixed, parameterised latency. The memory stage uses it as the backing store behind its request port.

## Interface
- `DEPTH_WORDS`, 512: number of 64-bit words in the array. Must be a power of two.
- `LATENCY`, 2: cycles from request accept to `rsp_valid_o` rising. Must be ≥ 1.
- `clk_i` input 1: the single clock. All state updates on its rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: a request is presented.
- `req_ready_o` output 1: the block can accept a request.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_funct3_i` input 3: access size and sign (RV64 load/store encoding).
- `req_addr_i` input 64: byte address.
- `req_wdata_i` input 64: store data, right-justified.
- `rsp_valid_o` output 1: a response is available.
- `rsp_ready_i` input 1: the consumer accepts the response.
- `rsp_rdata_o` output 64: load result, already extended. It is 0 for stores and errors.
- `rsp_err_o` output 1: misaligned access or illegal `funct3`.

## Operation
- FSM states are IDLE, WAIT and RESP.
- `req_ready_o` = (state == IDLE) and `rst_ni` high.
- **Accept:** IDLE and `req_valid_i` and `req_ready_o`.
  - Capture the error flag.
  - Perform the array write (stores) or read (loads) on the accept edge.
  - Register the extracted result.
  - Load the counter with `LATENCY-1`.
  - Go to WAIT, or directly to RESP if `LATENCY` == 1.
- **WAIT:** decrement the counter each cycle. On reaching 0, go to RESP.
- **RESP:**
  - Drive `rsp_valid_o` = 1 and hold `rsp_rdata_o`/`rsp_err_o` stable until `rsp_ready_i`.
  - On `rsp_valid_o` and `rsp_ready_i`, return to IDLE on the next edge.
- **Word index and offset:**
  - Word index = `req_addr_i[IDX_W+2:3]`, where IDX_W = log2(`DEPTH_WORDS`).
  - Upper address bits are ignored, so addresses alias modulo `DEPTH_WORDS`×8.
  - Byte offset `off` = `req_addr_i[2:0]`.
- **funct3 decoding:**
  - 000 = B, 001 = H, 010 = W, 011 = D: signed for loads, valid for stores.
  - 100 = BU, 101 = HU, 110 = WU: loads only.
  - 111 is illegal.
  - A store with `funct3` ≥ 100 is illegal.
- **Alignment:** H requires `off[0]`=0. W requires `off[1:0]`=0. D requires `off`=0.
- **Error response:** no array write, `rsp_rdata_o` = 0, `rsp_err_o` = 1. Latency is unchanged.
- **Stores:**
  - Byte strobes cover 1, 2, 4 or 8 lanes starting at `off`.
  - Write data is shifted left by `off`×8.
  - Only strobed bytes change.
  - The response carries rdata = 0 and err = 0.
- **Loads:**
  - Take the word, shift right by `off`×8, mask to the access size.
  - Sign-extend for B/H/W; zero-extend for BU/HU/WU/D.
- A write followed by a load to the same word sees the written data, because the write commits on the earlier accept edge.

## Timing
- **Reset values** (asynchronous assertion, applied immediately while `rst_ni` is low):
  - state = IDLE, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0, `req_ready_o` = 0.
  - `req_ready_o` rises in the first cycle after deassertion.
- Array contents are not reset and are undefined until written.
- **Latency:** accept at edge T gives `rsp_valid_o` high from T+`LATENCY` (visible after that edge).
- **Throughput:** best case is one request per `LATENCY`+1 cycles with `rsp_ready_i` tied high.
- `req_*` inputs are ignored outside IDLE, and no new request is accepted while a response is pending.
- **Reset mid-operation:** the pending response is discarded. A store already accepted remains committed.
- **Backpressure:** `rsp_ready_i` held low keeps the FSM in RESP indefinitely with outputs stable.

## Structure
- Package `mem_pkg` holds:
  - the `funct3` enum (`F3_B`…`F3_WU`);
  - the FSM state enum;
  - the localparam for word width (64).
- Sub-module `dmem_lane_align` is purely combinational. It takes `funct3`, `off`, wdata and the raw read word, and produces:
  - byte strobes;
  - shifted write data;
  - the extended load result;
  - the error flag.
- The top level holds the FSM, the counter, the array and the output registers.

## Test plan
- Reset: with `rst_ni`=0, all outputs are 0. On release, `req_ready_o`=1 after one cycle.
- Store/load round trip:
  - SD 0x8877665544332211 at addr 0x40; response err=0 arrives exactly `LATENCY` cycles after accept.
  - LD at 0x40 returns 0x8877665544332211.
  - LB at 0x47 returns 0xFFFFFFFFFFFFFF88.
  - LBU at 0x47 returns 0x88.
  - LHU at 0x42 returns 0x4433.
  - LW at 0x44 returns 0xFFFFFFFF88776655.
- Partial store: SB 0xAB at 0x41 over the word above, then LD at 0x40 returns 0x887766554433AB11.
- Errors:
  - LW at 0x42 gives err=1, rdata=0.
  - SH at 0x43 gives err=1, and a following LD shows the word unchanged.
  - `funct3`=111 gives err=1.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles in RESP. Outputs stay stable, `req_ready_o`=0 and a new `req_valid_i` is not accepted. Release; IDLE follows one cycle later.
- Aliasing and mid-op reset:
  - SD at 0x40 + `DEPTH_WORDS`×8 overwrites word 8.
  - Assert `rst_ni` during WAIT after a store: no response appears, and the stored data reads back after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

  localparam int XLEN = 64;

  // RV64 load/store size/sign encoding; 3'b111 is deliberately absent (illegal)
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, extension and alignment check
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic            we_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [7:0]      strb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o
);

  logic [1:0]      size;
  logic [7:0]      strb_base;
  logic [XLEN-1:0] sh;
  logic            err;

  // Decode size from funct3[1:0]; the unsigned variants share the signed sizes
  always_comb begin
    size      = funct3_i[1:0];
    strb_base = 8'h00;
    err       = (funct3_i == 3'b111) || (we_i && funct3_i[2]);
    sh        = raw_i >> {off_i, 3'b000};
    rdata_o   = '0;
    case (size)
      2'd0: strb_base = 8'h01;
      2'd1: begin strb_base = 8'h03; err = err | off_i[0];      end
      2'd2: begin strb_base = 8'h0F; err = err | (|off_i[1:0]); end
      default: begin strb_base = 8'hFF; err = err | (|off_i);   end
    endcase
    strb_o  = strb_base << off_i;
    wdata_o = wdata_i << {off_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{56{sh[7]}},  sh[7:0]};
      F3_H:    rdata_o = {{48{sh[15]}}, sh[15:0]};
      F3_W:    rdata_o = {{32{sh[31]}}, sh[31:0]};
      F3_D:    rdata_o = sh;
      F3_BU:   rdata_o = {56'd0, sh[7:0]};
      F3_HU:   rdata_o = {48'd0, sh[15:0]};
      F3_WU:   rdata_o = {32'd0, sh[31:0]};
      default: rdata_o = '0;
    endcase
    if (err || we_i) rdata_o = '0;
    err_o = err;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder over a 64-bit word array
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [2:0]       off;
  logic             accept;
  logic [7:0]       strb;
  logic [XLEN-1:0]  wdata_sh;
  logic [XLEN-1:0]  ld_data;
  logic             acc_err;
  logic             unused_addr;

  // Upper address bits alias onto the array
  assign idx         = req_addr_i[IDX_W+2:3];
  assign off         = req_addr_i[2:0];
  assign unused_addr = ^req_addr_i[XLEN-1:IDX_W+3];

  assign req_ready_o = (state_q == IDLE) && rst_ni;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == RESP);

  dmem_lane_align u_align (
    .funct3_i (req_funct3_i),
    .we_i     (req_we_i),
    .off_i    (off),
    .wdata_i  (req_wdata_i),
    .raw_i    (mem_q[idx]),
    .strb_o   (strb),
    .wdata_o  (wdata_sh),
    .rdata_o  (ld_data),
    .err_o    (acc_err)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: IDLE -> WAIT (or RESP when LATENCY is 1) -> RESP -> IDLE on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency counter and response registers, captured at accept and held until consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (accept) begin
      cnt_q       <= CNT_LOAD;
      rsp_rdata_o <= ld_data;
      rsp_err_o   <= acc_err;
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Array write commits on the accept edge so a following load sees it
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && !acc_err) begin
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;
  localparam int PER   = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [63:0] req_addr_i = 64'd0;
  logic [63:0] req_wdata_i = 64'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #(PER/2) clk_i = ~clk_i;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    time         t_acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl [DEPTH*8];
  int          nvec = 0;
  int          nfail = 0;
  int          nresp = 0;
  bit          in_resp = 0;
  logic [63:0] held_rdata;
  logic        held_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference memory: size, alignment and extension from plain arithmetic
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output logic err, output logic [63:0] rd);
    int sz;
    bit sgn;
    int base;
    logic [63:0] v;
    sz   = 1 << f3[1:0];
    sgn  = !f3[2] && (sz < 8);
    err  = (f3 == 3'd7) || (we && f3 >= 3'd4) || ((addr % 64'(sz)) != 0);
    base = int'(addr % 64'(DEPTH*8));
    rd   = 64'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mdl[base+i] = wd[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < sz; i++) v = v | (64'(mdl[base+i]) << (8*i));
        if (sgn && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        rd = v;
      end
    end
  endtask

  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] lit_rd, input logic lit_err, input bit wait_rsp);
    exp_t e;
    int   n0;
    bit   acc;
    @(posedge clk_i); #1;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    acc = 0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        @(posedge clk_i);
        acc = 1;
      end
    end
    if (!acc) begin
      nvec++; nfail++;
      $display("FAIL %s_accept: got no accept expected accept within 50 cycles", nm);
      req_valid_i = 1'b0;
      return;
    end
    e.t_acc = $time;
    model(we, f3, addr, wd, e.err, e.rdata);
    chk({nm, "_model_rdata"}, e.rdata, lit_rd);
    chk({nm, "_model_err"}, 64'(e.err), 64'(lit_err));
    n0 = nresp;
    exp_q.push_back(e);
    #1 req_valid_i = 1'b0;
    if (wait_rsp) begin
      for (int k = 0; k < 50 && nresp == n0; k++) @(negedge clk_i);
      if (nresp == n0) begin
        nvec++; nfail++;
        $display("FAIL %s_rsp: got no response expected one within 50 cycles", nm);
      end
    end
  endtask

  // Single compare process: checks every response cycle against the model queue
  always @(negedge clk_i) begin
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL spurious_rsp: got rsp_valid_o=1 expected 0");
      end else if (!in_resp) begin
        chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
        chk("rsp_err", 64'(rsp_err_o), 64'(exp_q[0].err));
        chk("rsp_latency", 64'($time - exp_q[0].t_acc), 64'(LAT*PER + PER/2));
        in_resp    = 1;
        held_rdata = rsp_rdata_o;
        held_err   = rsp_err_o;
      end else begin
        chk("hold_rdata", rsp_rdata_o, held_rdata);
        chk("hold_err", 64'(rsp_err_o), 64'(held_err));
      end
      if (rsp_ready_i && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        in_resp = 0;
        nresp++;
      end
    end
  end

  initial begin
    #(PER*20000);
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < DEPTH*8; i++) mdl[i] = 8'h00;

    repeat (2) @(negedge clk_i);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rdata", rsp_rdata_o, 64'd0);
    chk("rst_err", 64'(rsp_err_o), 64'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", 64'(req_ready_o), 64'd1);

    do_req("sd_40",  1, 3'd3, 64'h40, 64'h8877665544332211, 64'h0, 0, 1);
    do_req("ld_40",  0, 3'd3, 64'h40, 64'h0, 64'h8877665544332211, 0, 1);
    do_req("lb_47",  0, 3'd0, 64'h47, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 1);
    do_req("lbu_47", 0, 3'd4, 64'h47, 64'h0, 64'h88, 0, 1);
    do_req("lhu_42", 0, 3'd5, 64'h42, 64'h0, 64'h4433, 0, 1);
    do_req("lw_44",  0, 3'd2, 64'h44, 64'h0, 64'hFFFFFFFF88776655, 0, 1);
    do_req("lwu_44", 0, 3'd6, 64'h44, 64'h0, 64'h88776655, 0, 1);
    do_req("lh_46",  0, 3'd1, 64'h46, 64'h0, 64'hFFFFFFFFFFFF8877, 0, 1);
    do_req("sb_41",  1, 3'd0, 64'h41, 64'hAB, 64'h0, 0, 1);
    do_req("ld_sb",  0, 3'd3, 64'h40, 64'h0, 64'h887766554433AB11, 0, 1);
    do_req("lw_42",  0, 3'd2, 64'h42, 64'h0, 64'h0, 1, 1);
    do_req("sh_43",  1, 3'd1, 64'h43, 64'h1234, 64'h0, 1, 1);
    do_req("ld_sh",  0, 3'd3, 64'h40, 64'h0, 64'h887766554433AB11, 0, 1);
    do_req("f3_111", 0, 3'd7, 64'h40, 64'h0, 64'h0, 1, 1);
    do_req("st_f3_4",1, 3'd4, 64'h40, 64'hFF, 64'h0, 1, 1);
    do_req("ld_st4", 0, 3'd3, 64'h40, 64'h0, 64'h887766554433AB11, 0, 1);

    // Backpressure: response held while a stray request is presented
    @(posedge clk_i); #1 rsp_ready_i = 1'b0;
    do_req("ld_bp", 0, 3'd3, 64'h40, 64'h0, 64'h887766554433AB11, 0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      seen = rsp_valid_o;
    end
    chk("bp_rsp_seen", 64'(seen), 64'd1);
    repeat (5) begin
      @(posedge clk_i); #1;
      req_valid_i  = 1'b1;
      req_we_i     = 1'b1;
      req_funct3_i = 3'd3;
      req_addr_i   = 64'h40;
      req_wdata_i  = 64'h0;
      @(negedge clk_i);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("bp_idle_after", 64'(req_ready_o), 64'd1);
    chk("bp_valid_drop", 64'(rsp_valid_o), 64'd0);
    do_req("ld_after_bp", 0, 3'd3, 64'h40, 64'h0, 64'h887766554433AB11, 0, 1);

    // Aliasing modulo DEPTH*8 bytes
    do_req("sd_alias", 1, 3'd3, 64'h40 + 64'(DEPTH*8), 64'hDEADBEEFCAFEF00D, 64'h0, 0, 1);
    do_req("ld_alias", 0, 3'd3, 64'h40, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 1);

    // Reset during WAIT after a store
    do_req("sd_80", 1, 3'd3, 64'h80, 64'h0123456789ABCDEF, 64'h0, 0, 0);
    rst_ni = 1'b0;
    exp_q.delete();
    in_resp = 0;
    @(negedge clk_i);
    chk("midrst_valid", 64'(rsp_valid_o), 64'd0);
    chk("midrst_ready", 64'(req_ready_o), 64'd0);
    chk("midrst_rdata", rsp_rdata_o, 64'd0);
    chk("midrst_err", 64'(rsp_err_o), 64'd0);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("midrst_no_rsp", 64'(rsp_valid_o), 64'd0);
    do_req("ld_80", 0, 3'd3, 64'h80, 64'h0, 64'h0123456789ABCDEF, 0, 1);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
